// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi decoder frame sequencer,
// traceback unit and trellis/decoded-bit memories.
package viterbi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQ,
        ST_FLUSH,
        ST_TRACE,
        ST_OUT
    } vit_ctrl_state_t;

    localparam int FRAME_LEN_DEF = 256;
    localparam int ACS_LAT_DEF   = 2;
    localparam int TB_LAT_DEF    = 1;

    function automatic int vit_addr_w(input int frame_len);
        return (frame_len < 2) ? 1 : $clog2(frame_len);
    endfunction

endpackage

// File: rtl/vit_delay_line.sv
// Fixed-latency pipeline with synchronous clear; DEPTH=0 is a plain wire.
module vit_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: acquire pairs, flush ACS pipeline, trace back,
// then stream decoded bits out in forward order.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ACS_LAT   = ACS_LAT_DEF,
    parameter int TB_LAT    = TB_LAT_DEF,
    localparam int AW       = vit_addr_w(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          acs_en,
    output logic          acs_init,
    output logic          tm_we,
    output logic [AW-1:0] tm_waddr,
    output logic          tb_start,
    output logic          tb_en,
    output logic [AW-1:0] tm_raddr,
    output logic          dec_we,
    output logic [AW-1:0] dec_waddr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] dec_raddr,
    output logic          out_last,
    output logic          busy,
    output logic          frame_done
);

    // One counter serves every phase; it is reloaded on each transition.
    localparam int CW = $clog2(FRAME_LEN + ACS_LAT + TB_LAT + 1) + 1;

    localparam logic [CW-1:0] WR_LAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FL_LAST  = CW'(ACS_LAT - 1);
    localparam logic [CW-1:0] TB_STEPS = CW'(FRAME_LEN);
    localparam logic [CW-1:0] TR_LAST  = CW'(FRAME_LEN + TB_LAT - 1);
    localparam logic [AW-1:0] A_LAST   = AW'(FRAME_LEN - 1);

    vit_ctrl_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            tb_en_c;
    logic [AW-1:0]   raddr_c;
    logic [AW:0]     dly_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        acs_en    = 1'b0;
        acs_init  = 1'b0;
        tm_we     = 1'b0;
        tm_waddr  = '0;
        tb_start  = 1'b0;
        tb_en_c   = 1'b0;
        raddr_c   = '0;
        out_valid = 1'b0;
        dec_raddr = '0;
        out_last  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        acs_en   = 1'b1;
                        acs_init = 1'b1;
                        tm_we    = 1'b1;
                        state_d  = ST_ACQ;
                        cnt_d    = CW'(1);
                    end
                end
                ST_ACQ: begin
                    in_ready = 1'b1;
                    tm_waddr = cnt_q[AW-1:0];
                    if (in_valid) begin
                        acs_en = 1'b1;
                        tm_we  = 1'b1;
                        if (cnt_q == WR_LAST) begin
                            state_d = ST_FLUSH;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == FL_LAST) begin
                        state_d = ST_TRACE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_TRACE: begin
                    tb_start = (cnt_q == '0);
                    tb_en_c  = (cnt_q < TB_STEPS);
                    // Idle address is zero so the delayed tail stays clean.
                    if (tb_en_c) begin
                        raddr_c = A_LAST - cnt_q[AW-1:0];
                    end
                    if (cnt_q == TR_LAST) begin
                        state_d = ST_OUT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_OUT: begin
                    out_valid = 1'b1;
                    dec_raddr = cnt_q[AW-1:0];
                    out_last  = (cnt_q == WR_LAST);
                    if (out_ready) begin
                        if (cnt_q == WR_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    vit_delay_line #(
        .WIDTH (AW + 1),
        .DEPTH (TB_LAT)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({tb_en_c, raddr_c}),
        .q_o (dly_out)
    );

    assign tb_en      = tb_en_c;
    assign tm_raddr   = raddr_c;
    assign dec_we     = !rst && dly_out[AW];
    assign dec_waddr  = rst ? '0 : dly_out[AW-1:0];
    assign busy       = !rst && (state_q != ST_IDLE);
    assign frame_done = !rst && done_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: timeline model checked every cycle on two
// configurations (8/2/1 and 5/2/0) plus literal sequence checks.
module tb_viterbi_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst = 2'b11;
    logic [1:0] in_valid = 2'b00;
    logic [1:0] out_ready = 2'b00;
    logic [1:0] in_ready, acs_en, acs_init, tm_we, tb_start, tb_en;
    logic [1:0] dec_we, out_valid, out_last, busy, frame_done;
    logic [2:0] tm_waddr [2];
    logic [2:0] tm_raddr [2];
    logic [2:0] dec_waddr [2];
    logic [2:0] dec_raddr [2];

    viterbi_frame_ctrl #(.FRAME_LEN(8), .ACS_LAT(2), .TB_LAT(1)) u0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .acs_en(acs_en[0]),
        .acs_init(acs_init[0]), .tm_we(tm_we[0]),
        .tm_waddr(tm_waddr[0]), .tb_start(tb_start[0]),
        .tb_en(tb_en[0]), .tm_raddr(tm_raddr[0]),
        .dec_we(dec_we[0]), .dec_waddr(dec_waddr[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .dec_raddr(dec_raddr[0]), .out_last(out_last[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    viterbi_frame_ctrl #(.FRAME_LEN(5), .ACS_LAT(2), .TB_LAT(0)) u1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .acs_en(acs_en[1]),
        .acs_init(acs_init[1]), .tm_we(tm_we[1]),
        .tm_waddr(tm_waddr[1]), .tb_start(tb_start[1]),
        .tb_en(tb_en[1]), .tm_raddr(tm_raddr[1]),
        .dec_we(dec_we[1]), .dec_waddr(dec_waddr[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .dec_raddr(dec_raddr[1]), .out_last(out_last[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic int fl_of(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    function automatic int tl_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    task automatic chk(input int k, input string nm,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)",
                     k, nm, act, exp, cyc);
        end
    endtask

    // Model: pairs taken, cycles since the last pair, bits delivered.
    int nacc [2];
    int tpost [2];
    int nout [2];
    bit done_m [2];

    // Observation logs for literal checks.
    int n_acs [2], n_init [2], n_last [2], ov_n [2];
    int wa_log [2][16], wa_n [2];
    int ra_log [2][16], ra_n [2];
    int dw_log [2][16], dw_n [2];
    int hs_log [2][16], hs_n [2];
    int last_acc [2], tbs_n [2], tbs_cyc [2], tbs_first [2];
    int dw_first [2], ov_first [2], last_idx [2], hs_last_cyc [2];
    int fd_n [2], fd_cyc [2], fd_busy [2], init_fd [2];

    task automatic clr_log(input int k);
        n_acs[k] = 0; n_init[k] = 0; n_last[k] = 0; ov_n[k] = 0;
        wa_n[k] = 0; ra_n[k] = 0; dw_n[k] = 0; hs_n[k] = 0;
        last_acc[k] = -1; tbs_n[k] = 0; tbs_cyc[k] = -1;
        tbs_first[k] = -1; dw_first[k] = -1; ov_first[k] = -1;
        last_idx[k] = -1; hs_last_cyc[k] = -1;
        fd_n[k] = 0; fd_cyc[k] = -1; fd_busy[k] = -1; init_fd[k] = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int f, l, u;
            int e_rdy, e_acs, e_init, e_wa, e_tbs, e_tben, e_ra;
            int e_dwe, e_dwa, e_ov, e_rd, e_last, e_busy, e_fd;
            f = fl_of(k);
            l = tl_of(k);
            e_rdy = 0; e_acs = 0; e_init = 0; e_wa = 0;
            e_tbs = 0; e_tben = 0; e_ra = 0; e_dwe = 0; e_dwa = 0;
            e_ov = 0; e_rd = 0; e_last = 0; e_busy = 0; e_fd = 0;
            if (!rst[k]) begin
                e_fd = int'(done_m[k]);
                if (nacc[k] < f) begin
                    e_rdy  = 1;
                    e_acs  = int'(in_valid[k]);
                    e_init = (in_valid[k] && nacc[k] == 0) ? 1 : 0;
                    e_wa   = nacc[k];
                    e_busy = (nacc[k] != 0) ? 1 : 0;
                end else begin
                    e_busy = 1;
                    u = tpost[k] - 2;
                    if (u >= f + l) begin
                        e_ov   = 1;
                        e_rd   = nout[k];
                        e_last = (nout[k] == f - 1) ? 1 : 0;
                    end else if (u >= 0) begin
                        e_tbs  = (u == 0) ? 1 : 0;
                        e_tben = (u < f) ? 1 : 0;
                        e_ra   = (u < f) ? f - 1 - u : 0;
                        e_dwe  = (u - l >= 0) ? 1 : 0;
                        e_dwa  = (u - l >= 0) ? f - 1 - (u - l) : 0;
                    end
                end
            end
            chk(k, "in_ready", int'(in_ready[k]), e_rdy);
            chk(k, "acs_en", int'(acs_en[k]), e_acs);
            chk(k, "acs_init", int'(acs_init[k]), e_init);
            chk(k, "tm_we", int'(tm_we[k]), e_acs);
            chk(k, "tm_waddr", int'(tm_waddr[k]), e_wa);
            chk(k, "tb_start", int'(tb_start[k]), e_tbs);
            chk(k, "tb_en", int'(tb_en[k]), e_tben);
            chk(k, "tm_raddr", int'(tm_raddr[k]), e_ra);
            chk(k, "dec_we", int'(dec_we[k]), e_dwe);
            chk(k, "dec_waddr", int'(dec_waddr[k]), e_dwa);
            chk(k, "out_valid", int'(out_valid[k]), e_ov);
            chk(k, "dec_raddr", int'(dec_raddr[k]), e_rd);
            chk(k, "out_last", int'(out_last[k]), e_last);
            chk(k, "busy", int'(busy[k]), e_busy);
            chk(k, "frame_done", int'(frame_done[k]), e_fd);

            if (acs_en[k]) begin
                if (wa_n[k] < 16) wa_log[k][wa_n[k]] = int'(tm_waddr[k]);
                wa_n[k]++; n_acs[k]++; last_acc[k] = cyc;
            end
            if (acs_init[k]) n_init[k]++;
            if (tb_start[k]) begin
                tbs_n[k]++; tbs_cyc[k] = cyc;
                if (tbs_first[k] < 0) tbs_first[k] = cyc;
            end
            if (tb_en[k]) begin
                if (ra_n[k] < 16) ra_log[k][ra_n[k]] = int'(tm_raddr[k]);
                ra_n[k]++;
            end
            if (dec_we[k]) begin
                if (dw_n[k] < 16) dw_log[k][dw_n[k]] = int'(dec_waddr[k]);
                if (dw_first[k] < 0) dw_first[k] = cyc;
                dw_n[k]++;
            end
            if (out_valid[k]) begin
                if (ov_first[k] < 0) ov_first[k] = cyc;
                ov_n[k]++;
                if (out_ready[k]) begin
                    if (hs_n[k] < 16) hs_log[k][hs_n[k]] = int'(dec_raddr[k]);
                    if (out_last[k]) begin
                        n_last[k]++; last_idx[k] = hs_n[k];
                        hs_last_cyc[k] = cyc;
                    end
                    hs_n[k]++;
                end
            end
            if (frame_done[k]) begin
                fd_n[k]++; fd_cyc[k] = cyc; fd_busy[k] = int'(busy[k]);
                if (acs_init[k]) init_fd[k]++;
            end

            if (rst[k]) begin
                nacc[k] = 0; tpost[k] = 0; nout[k] = 0; done_m[k] = 0;
            end else begin
                done_m[k] = 0;
                if (nacc[k] < f) begin
                    if (in_valid[k]) begin
                        nacc[k]++;
                        if (nacc[k] == f) tpost[k] = 0;
                    end
                end else if (tpost[k] - 2 < f + l) begin
                    tpost[k]++;
                end else if (out_ready[k]) begin
                    if (nout[k] == f - 1) begin
                        nacc[k] = 0; nout[k] = 0; done_m[k] = 1;
                    end else begin
                        nout[k]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int k, input int npairs, input bit rnd);
        int guard;
        guard = 0;
        while (n_acs[k] < npairs && guard < 400) begin
            in_valid[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            guard++;
        end
        in_valid[k] = 1'b0;
        chk(k, "feed_timeout", int'(n_acs[k] >= npairs), 1);
    endtask

    task automatic wait_done(input int k, input int target);
        int guard;
        guard = 0;
        while (fd_n[k] < target && guard < 400) begin
            tick();
            guard++;
        end
        chk(k, "done_timeout", int'(fd_n[k] >= target), 1);
    endtask

    task automatic frame_lits0(input string tag);
        chk(0, {tag, "_acs_cnt"}, n_acs[0], 8);
        chk(0, {tag, "_init_cnt"}, n_init[0], 1);
        for (int i = 0; i < 8; i++) begin
            chk(0, {tag, "_waddr_seq"}, wa_log[0][i], i);
            chk(0, {tag, "_raddr_seq"}, ra_log[0][i], 7 - i);
            chk(0, {tag, "_dwaddr_seq"}, dw_log[0][i], 7 - i);
            chk(0, {tag, "_raddr_out"}, hs_log[0][i], i);
        end
        chk(0, {tag, "_tbstart_cnt"}, tbs_n[0], 1);
        chk(0, {tag, "_flush_gap"}, tbs_cyc[0] - last_acc[0], 3);
        chk(0, {tag, "_dec_lag"}, dw_first[0] - tbs_cyc[0], 1);
        chk(0, {tag, "_trace_len"}, ov_first[0] - tbs_cyc[0], 9);
        chk(0, {tag, "_last_idx"}, last_idx[0], 7);
        chk(0, {tag, "_last_cnt"}, n_last[0], 1);
        chk(0, {tag, "_done_lag"}, fd_cyc[0] - hs_last_cyc[0], 1);
        chk(0, {tag, "_done_busy"}, fd_busy[0], 0);
    endtask

    initial begin
        clr_log(0);
        clr_log(1);
        for (int k = 0; k < 2; k++) begin
            nacc[k] = 0; tpost[k] = 0; nout[k] = 0; done_m[k] = 0;
        end
        tick();
        chk(0, "rst_in_ready", int'(in_ready[0]), 0);
        chk(1, "rst_busy", int'(busy[1]), 0);
        tick();
        rst = 2'b00;
        tick();
        chk(0, "post_rst_ready", int'(in_ready[0]), 1);
        chk(1, "post_rst_ready", int'(in_ready[1]), 1);

        // Streaming frame, output always ready.
        clr_log(0);
        out_ready[0] = 1'b1;
        feed(0, 8, 1'b0);
        wait_done(0, 1);
        frame_lits0("t1");
        tick();

        // Bursty input, output stalled three cycles.
        clr_log(0);
        out_ready[0] = 1'b0;
        feed(0, 8, 1'b1);
        begin
            int guard;
            guard = 0;
            while (!out_valid[0] && guard < 100) begin
                tick();
                guard++;
            end
            chk(0, "ov_timeout", int'(out_valid[0]), 1);
        end
        repeat (3) tick();
        out_ready[0] = 1'b1;
        wait_done(0, 1);
        frame_lits0("t2");
        chk(0, "t2_ov_cycles", ov_n[0], 11);
        tick();

        // Reset mid-traceback, then a fresh frame.
        clr_log(0);
        in_valid[0] = 1'b1;
        begin
            int guard;
            guard = 0;
            while (!(tb_en[0] && tm_raddr[0] == 3'd4) && guard < 100) begin
                tick();
                if (n_acs[0] >= 8) in_valid[0] = 1'b0;
                guard++;
            end
            chk(0, "t3_reach_r4", int'(tm_raddr[0]), 4);
        end
        in_valid[0] = 1'b0;
        rst[0] = 1'b1;
        #1;
        chk(0, "t3_rst_tb_en", int'(tb_en[0]), 0);
        chk(0, "t3_rst_busy", int'(busy[0]), 0);
        chk(0, "t3_rst_ready", int'(in_ready[0]), 0);
        tick();
        rst[0] = 1'b0;
        #1;
        chk(0, "t3_idle_ready", int'(in_ready[0]), 1);
        chk(0, "t3_idle_busy", int'(busy[0]), 0);
        clr_log(0);
        feed(0, 8, 1'b0);
        wait_done(0, 1);
        frame_lits0("t3");
        tick();

        // FRAME_LEN=5, TB_LAT=0, back-to-back frames.
        clr_log(1);
        out_ready[1] = 1'b1;
        in_valid[1] = 1'b1;
        begin
            int guard;
            guard = 0;
            while (n_acs[1] < 10 && guard < 200) begin
                tick();
                guard++;
            end
        end
        in_valid[1] = 1'b0;
        wait_done(1, 2);
        chk(1, "t4_acs_cnt", n_acs[1], 10);
        chk(1, "t4_init_cnt", n_init[1], 2);
        chk(1, "t4_init_on_done", init_fd[1], 1);
        chk(1, "t4_dec_lag", dw_first[1] - tbs_first[1], 0);
        for (int i = 0; i < 10; i++) begin
            chk(1, "t4_waddr_seq", wa_log[1][i], i % 5);
            chk(1, "t4_raddr_seq", ra_log[1][i], 4 - (i % 5));
            chk(1, "t4_dwaddr_seq", dw_log[1][i], 4 - (i % 5));
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
